ccip_interface_pipe: RTL and testbench
======================================

CCIP_INTERFACE_PIPE -- requirements
Module: ccip_interface_pipe

Interface
REQ-001 Parameter RX_STAGES, default 2: Rx register stages, legal 1..4.
REQ-002 Parameter TX_STAGES, default 2: Tx register stages after the skid FIFO, legal 1..4.
REQ-003 Parameter RX_W, default 552: Rx payload bits; TX_W, default 614: Tx payload bits.
REQ-004 Parameter SKID_DEPTH, default 16: Tx skid FIFO entries, power of two, 4..64.
REQ-005 Parameter AFU_SLACK, default 8: requests the AFU may issue after seeing almFull; must satisfy AFU_SLACK < SKID_DEPTH.
REQ-006 pClk  in  1  sole clock.
REQ-007 pck_cp2af_softReset_n  in  1  reset, asynchronous, active-low.
REQ-008 rx_in_valid / rx_in_data  in  1 / RX_W  Rx from FIU.
REQ-009 rx_out_valid / rx_out_data  out  1 / RX_W  Rx to AFU.
REQ-010 afu_tx_valid / afu_tx_data  in  1 / TX_W  Tx request from AFU.
REQ-011 afu_tx_almFull  out  1  back-pressure to AFU.
REQ-012 fiu_tx_valid / fiu_tx_data  out  1 / TX_W  Tx request to FIU.
REQ-013 fiu_tx_almFull  in  1  FIU back-pressure.
REQ-014 afu_reset_n  out  1  retimed reset for AFU logic.
REQ-015 tx_overflow  out  1  sticky skid-overflow flag.
REQ-016 stat_tx_count / stat_stall_cycles  out  32 / 32  statistics (see Configuration).

Function
REQ-017 Rx path SHALL be a pure RX_STAGES-deep valid+data pipeline: rx_in sampled at edge k appears on rx_out after edge k+RX_STAGES-1; no back-pressure, no drops.
REQ-018 fiu_tx_almFull SHALL be registered once (almFull_q) before any use.
REQ-019 Tx request with afu_tx_valid=1 at edge k SHALL be written into the skid FIFO at edge k.
REQ-020 FIFO SHALL pop when count>0 and almFull_q=0; popped entry enters the TX_STAGES pipeline; minimum afu->fiu latency TX_STAGES+1 cycles.
REQ-021 fiu_tx_valid SHALL be 1 for exactly one cycle per popped entry, in AFU issue order; data unchanged.
REQ-022 afu_tx_almFull SHALL be registered: next = (count_next >= SKID_DEPTH-AFU_SLACK) OR almFull_q.
REQ-023 Push and pop in same cycle SHALL leave count unchanged, including when full (push accepted).
REQ-024 Push when full with no pop SHALL drop the request, leave FIFO contents intact, and set tx_overflow until reset.
REQ-025 Count and pointers SHALL wrap modulo SKID_DEPTH; count width clog2(SKID_DEPTH)+1.
REQ-026 afu_reset_n SHALL assert asynchronously with reset and deassert synchronously RX_STAGES edges after reset release.

Reset
REQ-027 On reset assertion, immediately: all valids 0, FIFO empty, pipelines cleared, tx_overflow 0, stat counters 0, afu_tx_almFull 1, afu_reset_n 0.
REQ-028 Reset mid-operation SHALL discard all in-flight Rx/Tx entries; none emitted after release.
REQ-029 Data registers need no reset; only valid/control state is reset.

Configuration
REQ-030 Macro CCIP_PIPE_STATS_EN defined: stat_tx_count increments per fiu_tx_valid, stat_stall_cycles increments per cycle with count>0 and almFull_q=1; both saturate at 0xFFFFFFFF.
REQ-031 Macro undefined: both stat outputs tied to 0, no counter flops.

Structure
REQ-032 Package ccip_pipe_pkg SHALL hold stage-limit constants, SKID_DEPTH legality checks and the count-width function.
REQ-033 Skid FIFO SHALL be sub-module ccip_pipe_skid_fifo (push, pop, count, full, empty, registered read data).
REQ-034 Illegal parameter combinations SHALL fail elaboration.

Verification
REQ-035 Rx: RX_STAGES=3, pulse rx_in_valid with data 0xA5 -> rx_out_valid high one cycle, 0xA5, 3 cycles later, no other pulses.
REQ-036 Tx idle: TX_STAGES=2, single request D=0x1234 -> fiu_tx_valid with 0x1234 exactly 3 cycles later.
REQ-037 Back-pressure: hold fiu_tx_almFull=1, AFU issues 8 back-to-back -> afu_tx_almFull 1 after count reaches 8; deassert -> 8 emitted in order, no loss.
REQ-038 Overflow: SKID_DEPTH=16, almFull held, 17 pushes -> first 16 retained, tx_overflow=1, 16 emitted after release.
REQ-039 Reset mid-burst: assert reset with 5 queued -> outputs cleared same cycle, afu_tx_almFull=1, no emission after release, afu_reset_n rises RX_STAGES cycles after release.
REQ-040 Stats build: 10 requests, 4 stalled cycles -> stat_tx_count=10, stat_stall_cycles=4; non-stats build reads 0.

Source files
------------

// File: rtl/ccip_pipe_pkg.sv
// ccip_pipe_pkg: shared constants and helpers for the CCI-P interface pipe.
//   - Stage-count limits for the Rx and Tx register pipelines.
//   - Skid FIFO depth limits and legality check (power of two, 4..64).
//   - countWidth(): FIFO occupancy counter width, clog2(depth)+1 so "full" is representable.
package ccip_pipe_pkg;

    localparam int unsigned MIN_STAGES     = 1;
    localparam int unsigned MAX_STAGES     = 4;
    localparam int unsigned MIN_SKID_DEPTH = 4;
    localparam int unsigned MAX_SKID_DEPTH = 64;

    function automatic int unsigned countWidth(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit isPow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit skidDepthLegal(input int unsigned depth);
        return isPow2(depth) && (depth >= MIN_SKID_DEPTH) && (depth <= MAX_SKID_DEPTH);
    endfunction

    function automatic bit stagesLegal(input int unsigned stages);
        return (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
    endfunction

endpackage

// File: rtl/ccip_pipe_skid_fifo.sv
// ccip_pipe_skid_fifo: Tx skid buffer between the AFU and the Tx register pipeline.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wrData      write request; accepted when not full, or when full with a same-cycle pop
//   pop               read request; ignored when empty
//   count             registered occupancy (0..DEPTH)
//   full, empty       occupancy flags derived from count
//   rdValid, rdData   registered read port, valid the cycle after an accepted pop
module ccip_pipe_skid_fifo
    import ccip_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 614,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = countWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wrData,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             rdValid,
    output logic [WIDTH-1:0] rdData
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rdValid_q;
    logic [WIDTH-1:0] rdData_q;
    logic             doPush, doPop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        doPop   = pop && !empty;
        // A full FIFO still accepts a write when the same cycle frees a slot.
        doPush  = push && (!full || doPop);
        count_d = count_q + CW'(doPush) - CW'(doPop);
        // Power-of-two depth: pointers wrap by natural overflow.
        wrPtr_d = doPush ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + AW'(1) : rdPtr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            rdValid_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            rdValid_q <= doPop;
        end
    end

    // Storage and read register carry no reset; validity lives in the control flops.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= wrData;
        end
        if (doPop) begin
            rdData_q <= mem[rdPtr_q];
        end
    end

    assign count   = count_q;
    assign rdValid = rdValid_q;
    assign rdData  = rdData_q;

endmodule

// File: rtl/ccip_interface_pipe.sv
// ccip_interface_pipe: retiming shell between the FIU and an AFU on a CCI-P style link.
//   Rx: fixed-latency valid+data pipeline (RX_STAGES registers), no back-pressure.
//   Tx: AFU requests land in a skid FIFO, drain into a TX_STAGES register pipeline while the
//       registered FIU almFull is low; afu_tx_almFull is raised early enough that AFU_SLACK
//       further requests still fit.
// Ports:
//   pClk, pck_cp2af_softReset_n       clock, asynchronous active-low reset
//   rx_in_valid/data  -> rx_out_valid/data
//   afu_tx_valid/data -> fiu_tx_valid/data, afu_tx_almFull back to the AFU
//   fiu_tx_almFull                    FIU back-pressure (registered before use)
//   afu_reset_n                       reset for AFU logic, released RX_STAGES edges after ours
//   tx_overflow                       sticky: a request was dropped on a full skid FIFO
//   stat_tx_count/stat_stall_cycles   saturating statistics
// Build option: define CCIP_PIPE_STATS_EN to implement the statistics counters; otherwise the
// stat outputs are tied to zero.
module ccip_interface_pipe
    import ccip_pipe_pkg::*;
#(
    parameter int unsigned RX_STAGES  = 2,
    parameter int unsigned TX_STAGES  = 2,
    parameter int unsigned RX_W       = 552,
    parameter int unsigned TX_W       = 614,
    parameter int unsigned SKID_DEPTH = 16,
    parameter int unsigned AFU_SLACK  = 8
) (
    input  logic            pClk,
    input  logic            pck_cp2af_softReset_n,
    input  logic            rx_in_valid,
    input  logic [RX_W-1:0] rx_in_data,
    output logic            rx_out_valid,
    output logic [RX_W-1:0] rx_out_data,
    input  logic            afu_tx_valid,
    input  logic [TX_W-1:0] afu_tx_data,
    output logic            afu_tx_almFull,
    output logic            fiu_tx_valid,
    output logic [TX_W-1:0] fiu_tx_data,
    input  logic            fiu_tx_almFull,
    output logic            afu_reset_n,
    output logic            tx_overflow,
    output logic [31:0]     stat_tx_count,
    output logic [31:0]     stat_stall_cycles
);

    localparam int unsigned CW        = countWidth(SKID_DEPTH);
    localparam int unsigned ALM_LEVEL = SKID_DEPTH - AFU_SLACK;

    if (!stagesLegal(RX_STAGES) || !stagesLegal(TX_STAGES) || !skidDepthLegal(SKID_DEPTH) ||
        (AFU_SLACK >= SKID_DEPTH) || (RX_W == 0) || (TX_W == 0)) begin : gIllegalParams
        $error("ccip_interface_pipe: illegal parameter combination");
    end

    //--------------------------------------------------------------------------
    // Rx pipeline
    //--------------------------------------------------------------------------
    logic            rxValid_q [RX_STAGES];
    logic [RX_W-1:0] rxData_q  [RX_STAGES];

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            for (int i = 0; i < RX_STAGES; i++) rxValid_q[i] <= 1'b0;
        end else begin
            rxValid_q[0] <= rx_in_valid;
            for (int i = 1; i < RX_STAGES; i++) rxValid_q[i] <= rxValid_q[i-1];
        end
    end

    always_ff @(posedge pClk) begin
        rxData_q[0] <= rx_in_data;
        for (int i = 1; i < RX_STAGES; i++) rxData_q[i] <= rxData_q[i-1];
    end

    assign rx_out_valid = rxValid_q[RX_STAGES-1];
    assign rx_out_data  = rxData_q[RX_STAGES-1];

    //--------------------------------------------------------------------------
    // AFU reset: asynchronous assert, synchronous release after RX_STAGES edges
    //--------------------------------------------------------------------------
    logic rstSync_q [RX_STAGES];

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            for (int i = 0; i < RX_STAGES; i++) rstSync_q[i] <= 1'b0;
        end else begin
            rstSync_q[0] <= 1'b1;
            for (int i = 1; i < RX_STAGES; i++) rstSync_q[i] <= rstSync_q[i-1];
        end
    end

    assign afu_reset_n = rstSync_q[RX_STAGES-1];

    //--------------------------------------------------------------------------
    // Tx skid FIFO and flow control
    //--------------------------------------------------------------------------
    logic            almFull_q;
    logic            afuAlmFull_q;
    logic            overflow_q;
    logic            txPop, txPushAccept, txDrop;
    logic [CW-1:0]   fifoCount, txCountNext;
    logic            fifoFull, fifoEmpty, fifoRdValid;
    logic [TX_W-1:0] fifoRdData;

    always_comb begin
        txPop        = !fifoEmpty && !almFull_q;
        txPushAccept = afu_tx_valid && (!fifoFull || txPop);
        txDrop       = afu_tx_valid && fifoFull && !txPop;
        txCountNext  = fifoCount + CW'(txPushAccept) - CW'(txPop);
    end

    ccip_pipe_skid_fifo #(
        .WIDTH (TX_W),
        .DEPTH (SKID_DEPTH)
    ) uSkidFifo (
        .clk     (pClk),
        .rst_n   (pck_cp2af_softReset_n),
        .push    (afu_tx_valid),
        .wrData  (afu_tx_data),
        .pop     (txPop),
        .count   (fifoCount),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .rdValid (fifoRdValid),
        .rdData  (fifoRdData)
    );

    // almFull flops reset high so the AFU stays quiet until the first sampled FIU state.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            almFull_q    <= 1'b1;
            afuAlmFull_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            almFull_q    <= fiu_tx_almFull;
            afuAlmFull_q <= (txCountNext >= CW'(ALM_LEVEL)) || almFull_q;
            overflow_q   <= overflow_q || txDrop;
        end
    end

    assign afu_tx_almFull = afuAlmFull_q;
    assign tx_overflow    = overflow_q;

    //--------------------------------------------------------------------------
    // Tx pipeline after the FIFO read register
    //--------------------------------------------------------------------------
    logic            txValid_q [TX_STAGES];
    logic [TX_W-1:0] txData_q  [TX_STAGES];

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            for (int i = 0; i < TX_STAGES; i++) txValid_q[i] <= 1'b0;
        end else begin
            txValid_q[0] <= fifoRdValid;
            for (int i = 1; i < TX_STAGES; i++) txValid_q[i] <= txValid_q[i-1];
        end
    end

    always_ff @(posedge pClk) begin
        txData_q[0] <= fifoRdData;
        for (int i = 1; i < TX_STAGES; i++) txData_q[i] <= txData_q[i-1];
    end

    assign fiu_tx_valid = txValid_q[TX_STAGES-1];
    assign fiu_tx_data  = txData_q[TX_STAGES-1];

    //--------------------------------------------------------------------------
    // Statistics
    //--------------------------------------------------------------------------
`ifdef CCIP_PIPE_STATS_EN
    logic [31:0] statTx_q, statStall_q;

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            statTx_q    <= '0;
            statStall_q <= '0;
        end else begin
            if (fiu_tx_valid && (statTx_q != '1)) begin
                statTx_q <= statTx_q + 32'd1;
            end
            if (!fifoEmpty && almFull_q && (statStall_q != '1)) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end

    assign stat_tx_count     = statTx_q;
    assign stat_stall_cycles = statStall_q;
`else
    assign stat_tx_count     = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ccip_interface_pipe.sv
// Self-checking bench for ccip_interface_pipe: directed vector table, hand-written corner
// sequences and a randomized run, all checked every cycle against a queue-based model.
module tb_ccip_interface_pipe;

    localparam int RX_STAGES  = 3;
    localparam int TX_STAGES  = 2;
    localparam int RX_W       = 552;
    localparam int TX_W       = 614;
    localparam int SKID_DEPTH = 16;
    localparam int AFU_SLACK  = 8;

    logic            pClk = 1'b0;
    logic            rst_n;
    logic            rx_in_valid;
    logic [RX_W-1:0] rx_in_data;
    logic            rx_out_valid;
    logic [RX_W-1:0] rx_out_data;
    logic            afu_tx_valid;
    logic [TX_W-1:0] afu_tx_data;
    logic            afu_tx_almFull;
    logic            fiu_tx_valid;
    logic [TX_W-1:0] fiu_tx_data;
    logic            fiu_tx_almFull;
    logic            afu_reset_n;
    logic            tx_overflow;
    logic [31:0]     stat_tx_count;
    logic [31:0]     stat_stall_cycles;

    ccip_interface_pipe #(
        .RX_STAGES  (RX_STAGES),
        .TX_STAGES  (TX_STAGES),
        .RX_W       (RX_W),
        .TX_W       (TX_W),
        .SKID_DEPTH (SKID_DEPTH),
        .AFU_SLACK  (AFU_SLACK)
    ) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .rx_in_valid           (rx_in_valid),
        .rx_in_data            (rx_in_data),
        .rx_out_valid          (rx_out_valid),
        .rx_out_data           (rx_out_data),
        .afu_tx_valid          (afu_tx_valid),
        .afu_tx_data           (afu_tx_data),
        .afu_tx_almFull        (afu_tx_almFull),
        .fiu_tx_valid          (fiu_tx_valid),
        .fiu_tx_data           (fiu_tx_data),
        .fiu_tx_almFull        (fiu_tx_almFull),
        .afu_reset_n           (afu_reset_n),
        .tx_overflow           (tx_overflow),
        .stat_tx_count         (stat_tx_count),
        .stat_stall_cycles     (stat_stall_cycles)
    );

    always #5 pClk = ~pClk;

    //--------------------------------------------------------------------------
    // Reference model: skid contents as a queue, outputs as (data, due-edge) queues
    //--------------------------------------------------------------------------
    typedef struct {
        logic [TX_W-1:0] data;
        int              due;
    } txExp_t;

    typedef struct {
        logic [RX_W-1:0] data;
        int              due;
    } rxExp_t;

    logic [TX_W-1:0] skidQ[$];
    txExp_t          txExpQ[$];
    rxExp_t          rxExpQ[$];

    int          nTests = 0;
    int          nFail  = 0;
    int          cyc    = 0;
    int          relEdges;
    int          txSeen = 0;
    bit          almQ, afuAlmExp, ovfExp, inReset, emittedPrev;
    int unsigned statTx, statStall;

    task automatic cmp(input string name, input logic [639:0] got, input logic [639:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [639:0] rand640();
        logic [639:0] t;
        for (int i = 0; i < 20; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    task automatic modelClear();
        skidQ.delete();
        txExpQ.delete();
        rxExpQ.delete();
        almQ        = 1'b1;
        afuAlmExp   = 1'b1;
        ovfExp      = 1'b0;
        statTx      = 0;
        statStall   = 0;
        relEdges    = 0;
        emittedPrev = 1'b0;
    endtask

    // Called at each rising edge with the inputs that were set up before it.
    task automatic modelEdge();
        txExp_t t;
        rxExp_t r;
        bit     pop;
        cyc++;
        if (inReset) return;
        if (relEdges < 1000) relEdges++;
        if (emittedPrev) statTx++;
        if (skidQ.size() != 0 && almQ) statStall++;
        pop = (skidQ.size() != 0) && !almQ;
        if (pop) begin
            t.data = skidQ.pop_front();
            t.due  = cyc + TX_STAGES;
            txExpQ.push_back(t);
        end
        if (afu_tx_valid) begin
            if (skidQ.size() < SKID_DEPTH) skidQ.push_back(afu_tx_data);
            else ovfExp = 1'b1;
        end
        afuAlmExp = (skidQ.size() >= SKID_DEPTH - AFU_SLACK) || almQ;
        almQ      = fiu_tx_almFull;
        if (rx_in_valid) begin
            r.data = rx_in_data;
            r.due  = cyc + RX_STAGES - 1;
            rxExpQ.push_back(r);
        end
    endtask

    task automatic check();
        bit expV;
        expV = (rxExpQ.size() != 0) && (rxExpQ[0].due == cyc);
        cmp("rx_out_valid", 640'(rx_out_valid), 640'(expV));
        if (expV) begin
            cmp("rx_out_data", 640'(rx_out_data), 640'(rxExpQ[0].data));
            void'(rxExpQ.pop_front());
        end
        expV = (txExpQ.size() != 0) && (txExpQ[0].due == cyc);
        cmp("fiu_tx_valid", 640'(fiu_tx_valid), 640'(expV));
        if (expV) begin
            cmp("fiu_tx_data", 640'(fiu_tx_data), 640'(txExpQ[0].data));
            void'(txExpQ.pop_front());
        end
        emittedPrev = expV;
        if (fiu_tx_valid) txSeen++;
        cmp("afu_tx_almFull", 640'(afu_tx_almFull), 640'(afuAlmExp));
        cmp("tx_overflow", 640'(tx_overflow), 640'(ovfExp));
        cmp("afu_reset_n", 640'(afu_reset_n), 640'(!inReset && relEdges >= RX_STAGES));
`ifdef CCIP_PIPE_STATS_EN
        cmp("stat_tx_count", 640'(stat_tx_count), 640'(statTx));
        cmp("stat_stall_cycles", 640'(stat_stall_cycles), 640'(statStall));
`else
        cmp("stat_tx_count", 640'(stat_tx_count), 640'(0));
        cmp("stat_stall_cycles", 640'(stat_stall_cycles), 640'(0));
`endif
    endtask

    task automatic cycle();
        @(posedge pClk);
        modelEdge();
        #1;
        check();
    endtask

    // Asserted between edges to exercise the asynchronous path.
    task automatic assertReset();
        #2;
        rst_n = 1'b0;
        inReset = 1'b1;
        modelClear();
        #1;
        check();
    endtask

    task automatic releaseReset();
        #2;
        rst_n = 1'b1;
        inReset = 1'b0;
    endtask

    task automatic idleInputs();
        rx_in_valid    = 1'b0;
        afu_tx_valid   = 1'b0;
        fiu_tx_almFull = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        assertReset();
        repeat (2) cycle();
        releaseReset();
        repeat (RX_STAGES + 2) cycle();
    endtask

    //--------------------------------------------------------------------------
    // Directed single-transfer vectors; latency counted in edges after the sampling edge
    //--------------------------------------------------------------------------
    typedef struct {
        bit          isTx;
        logic [31:0] data;
        int          expLat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          seenLat, pulses, rise, base;
        logic [31:0] seenData;
        bit          v;

        vecs[0] = '{isTx: 1'b0, data: 32'h0000_00A5, expLat: 2};
        vecs[1] = '{isTx: 1'b0, data: 32'h0000_5A3C, expLat: 2};
        vecs[2] = '{isTx: 1'b0, data: 32'hFFFF_FFFF, expLat: 2};
        vecs[3] = '{isTx: 1'b1, data: 32'h0000_1234, expLat: 3};
        vecs[4] = '{isTx: 1'b1, data: 32'hDEAD_BEEF, expLat: 3};
        vecs[5] = '{isTx: 1'b1, data: 32'h0000_0000, expLat: 3};

        rst_n       = 1'b1;
        rx_in_data  = '0;
        afu_tx_data = '0;
        idleInputs();
        inReset = 1'b1;
        modelClear();
        #1;
        rst_n = 1'b0;
        #1;
        check();
        repeat (3) cycle();
        releaseReset();
        repeat (RX_STAGES + 3) cycle();

        // ---- vector table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].isTx) begin
                afu_tx_data       = '0;
                afu_tx_data[31:0] = vecs[i].data;
                afu_tx_valid      = 1'b1;
            end else begin
                rx_in_data        = '0;
                rx_in_data[31:0]  = vecs[i].data;
                rx_in_valid       = 1'b1;
            end
            seenLat  = -1;
            pulses   = 0;
            seenData = '0;
            for (int j = 0; j < 9; j++) begin
                cycle();
                afu_tx_valid = 1'b0;
                rx_in_valid  = 1'b0;
                v = vecs[i].isTx ? fiu_tx_valid : rx_out_valid;
                if (v) begin
                    pulses++;
                    if (seenLat < 0) begin
                        seenLat  = j;
                        seenData = vecs[i].isTx ? fiu_tx_data[31:0] : rx_out_data[31:0];
                    end
                end
            end
            cmp("vec latency", 640'(seenLat), 640'(vecs[i].expLat));
            cmp("vec pulses", 640'(pulses), 640'(1));
            cmp("vec data", 640'(seenData), 640'(vecs[i].data));
        end

        // ---- back-pressure: 8 queued while FIU is almost full, then drained in order
        fiu_tx_almFull = 1'b1;
        repeat (2) cycle();
        base = txSeen;
        for (int i = 0; i < 8; i++) begin
            afu_tx_valid = 1'b1;
            afu_tx_data  = rand640()[TX_W-1:0];
            cycle();
        end
        afu_tx_valid = 1'b0;
        cycle();
        cmp("bp almFull", 640'(afu_tx_almFull), 640'(1));
        cmp("bp held", 640'(txSeen - base), 640'(0));
        fiu_tx_almFull = 1'b0;
        repeat (20) cycle();
        cmp("bp drained", 640'(txSeen - base), 640'(8));

        // ---- overflow: 17 pushes into a 16-deep FIFO with the FIU blocked
        doReset();
        fiu_tx_almFull = 1'b1;
        repeat (2) cycle();
        base = txSeen;
        for (int i = 0; i < 17; i++) begin
            afu_tx_valid = 1'b1;
            afu_tx_data  = rand640()[TX_W-1:0];
            cycle();
            if (i == 15) cmp("ovf at 16", 640'(tx_overflow), 640'(0));
        end
        afu_tx_valid = 1'b0;
        cycle();
        cmp("ovf flag", 640'(tx_overflow), 640'(1));
        fiu_tx_almFull = 1'b0;
        repeat (30) cycle();
        cmp("ovf drained", 640'(txSeen - base), 640'(16));
        cmp("ovf sticky", 640'(tx_overflow), 640'(1));

        // ---- reset mid-burst: 5 queued, draining has begun, Rx pulse in flight
        doReset();
        fiu_tx_almFull = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            afu_tx_valid = 1'b1;
            afu_tx_data  = rand640()[TX_W-1:0];
            cycle();
        end
        afu_tx_valid   = 1'b0;
        fiu_tx_almFull = 1'b0;
        repeat (2) cycle();
        rx_in_valid = 1'b1;
        rx_in_data  = rand640()[RX_W-1:0];
        cycle();
        rx_in_valid = 1'b0;
        base = txSeen;
        assertReset();
        cmp("rst fiu_tx_valid", 640'(fiu_tx_valid), 640'(0));
        cmp("rst rx_out_valid", 640'(rx_out_valid), 640'(0));
        cmp("rst afu_tx_almFull", 640'(afu_tx_almFull), 640'(1));
        cmp("rst afu_reset_n", 640'(afu_reset_n), 640'(0));
        repeat (2) cycle();
        releaseReset();
        rise = -1;
        for (int j = 1; j <= 10; j++) begin
            cycle();
            if (afu_reset_n && rise < 0) rise = j;
        end
        cmp("rst afu_reset_n rise", 640'(rise), 640'(RX_STAGES));
        cmp("rst no emission", 640'(txSeen - base), 640'(0));

        // ---- statistics: 10 requests, FIU blocking so that exactly 4 cycles stall
        doReset();
        fiu_tx_almFull = 1'b1;
        repeat (3) cycle();
        for (int i = 0; i < 10; i++) begin
            fiu_tx_almFull = (i < 4);
            afu_tx_valid   = 1'b1;
            afu_tx_data    = rand640()[TX_W-1:0];
            cycle();
        end
        afu_tx_valid   = 1'b0;
        fiu_tx_almFull = 1'b0;
        repeat (30) cycle();
`ifdef CCIP_PIPE_STATS_EN
        cmp("stats tx count", 640'(stat_tx_count), 640'(10));
        cmp("stats stall", 640'(stat_stall_cycles), 640'(4));
`else
        cmp("stats tx count off", 640'(stat_tx_count), 640'(0));
        cmp("stats stall off", 640'(stat_stall_cycles), 640'(0));
`endif

        // ---- randomized traffic with bursty FIU back-pressure and one mid-run reset
        doReset();
        for (int n = 0; n < 2000; n++) begin
            afu_tx_valid = ($urandom_range(0, 99) < 60);
            afu_tx_data  = rand640()[TX_W-1:0];
            rx_in_valid  = ($urandom_range(0, 99) < 50);
            rx_in_data   = rand640()[RX_W-1:0];
            if ($urandom_range(0, 99) < 10) fiu_tx_almFull = !fiu_tx_almFull;
            if (n == 1000) begin
                assertReset();
                repeat (2) cycle();
                releaseReset();
            end
            cycle();
        end
        idleInputs();
        repeat (40) cycle();
        cmp("rand drained tx", 640'(txExpQ.size()), 640'(0));
        cmp("rand drained rx", 640'(rxExpQ.size()), 640'(0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
